// File: rtl/composer_line_reader_if.sv
// Bundles the composer line reader's control, line-buffer and pixel-stream signals.
// The hoffset port exists only when COMPOSER_LINE_READER_HOFFSET_EN is defined.
interface composer_line_reader_if;
    logic       line_start;
    logic       pixel_en;
    logic [7:0] hscale;
`ifdef COMPOSER_LINE_READER_HOFFSET_EN
    logic [9:0] hoffset;
`endif
    logic [9:0] composer_rd_idx;
    logic [7:0] composer_rd_data;
    logic [7:0] pixel_out;
    logic       pixel_valid;
    logic       line_done;
    logic       busy;
    logic [1:0] state_dbg;

    // pixel_valid qualifies pixel_out for exactly one cycle; there is no ready,
    // the composer must accept every valid pixel.
    modport master (
`ifdef COMPOSER_LINE_READER_HOFFSET_EN
        output hoffset,
`endif
        output line_start, pixel_en, hscale, composer_rd_data,
        input  composer_rd_idx, pixel_out, pixel_valid, line_done, busy, state_dbg
    );

    modport slave (
`ifdef COMPOSER_LINE_READER_HOFFSET_EN
        input  hoffset,
`endif
        input  line_start, pixel_en, hscale, composer_rd_data,
        output composer_rd_idx, pixel_out, pixel_valid, line_done, busy, state_dbg
    );
endinterface

// File: rtl/composer_line_reader.sv
// Walks a horizontally scaled source position per line, reads the line buffer and
// emits a 2-cycle-latency pixel stream. Optional start offset: COMPOSER_LINE_READER_HOFFSET_EN.
module composer_line_reader #(
    parameter int ACTIVE_WIDTH = 640,
    parameter int LINE_LEN     = 768,
    parameter int FRAC_BITS    = 7
) (
    input logic                   clk,
    input logic                   rst,
    composer_line_reader_if.slave bus
);
    localparam int ACC_W = 11 + FRAC_BITS;
    localparam logic [10:0] LINE_LEN_W = 11'(LINE_LEN);
    localparam logic [9:0]  CNT_LAST   = 10'(ACTIVE_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [9:0]       cnt_q, cnt_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_oob_q, s1_oob_d;
    logic [7:0]       pix_q, pix_d;
    logic             pix_valid_q, pix_valid_d;
    logic             done_q, done_d;
    logic [10:0]      pos;
    logic [ACC_W-1:0] start_acc;

    assign pos = acc_q[ACC_W-1:FRAC_BITS];

`ifdef COMPOSER_LINE_READER_HOFFSET_EN
    assign start_acc = {1'b0, bus.hoffset, {FRAC_BITS{1'b0}}};
`else
    assign start_acc = '0;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        s1_valid_d  = 1'b0;
        s1_oob_d    = 1'b0;
        pix_valid_d = s1_valid_q;
        pix_d       = pix_q;
        done_d      = 1'b0;
        // Stage 2 samples the buffer data one cycle after the index was presented.
        if (s1_valid_q) begin
            pix_d = s1_oob_q ? 8'h00 : bus.composer_rd_data;
        end
        if (bus.line_start) begin
            state_d     = S_RUN;
            acc_d       = start_acc;
            cnt_d       = '0;
            pix_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (bus.pixel_en) begin
                        acc_d      = acc_q + {{(ACC_W-8){1'b0}}, bus.hscale};
                        cnt_d      = cnt_q + 10'd1;
                        s1_valid_d = 1'b1;
                        s1_oob_d   = (pos >= LINE_LEN_W);
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!s1_valid_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_oob_q    <= 1'b0;
            pix_q       <= 8'h00;
            pix_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_oob_q    <= s1_oob_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.composer_rd_idx = pos[9:0];
    assign bus.pixel_out       = pix_q;
    assign bus.pixel_valid     = pix_valid_q;
    assign bus.line_done       = done_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.state_dbg       = state_q;
endmodule
